// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared constants for the single-port-RAM FIFO controller: RAM command
// encodings ({CEN, WEN}, active low) and the output buffer depth.
package spram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    RAM_WRITE = 2'b00,
    RAM_READ  = 2'b01,
    RAM_IDLE  = 2'b11
  } ram_cmd_e;

  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/spram_fifo_obuf.sv
// Two-entry output buffer that catches RAM read data and presents the head word
// with valid/ready; the head stays put until it is popped.
module spram_fifo_obuf
  import spram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
  logic                  wr_idx_q, wr_idx_d;
  logic                  rd_idx_q, rd_idx_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop;

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = mem_q[rd_idx_q];
  assign occ_o       = occ_q;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    wr_idx_d = wr_idx_q ^ push_i;
    rd_idx_d = rd_idx_q ^ pop;
    occ_d    = occ_q + {1'b0, push_i} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx_q] <= push_data_i;
  end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller over an external single-port RAM (1-cycle read latency).
// Handshakes: a word moves on a rising edge where valid & ready are both high.
module spram_fifo_ctrl
  import spram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     ram_CEN,
  output logic                     ram_WEN,
  output logic [$clog2(DEPTH)-1:0] ram_A,
  output logic [DATA_WIDTH-1:0]    ram_D,
  input  logic [DATA_WIDTH-1:0]    ram_Q,
  output logic [$clog2(DEPTH)+1:0] count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          arb_q, arb_d;
  logic [AW+1:0] count_q, count_d;
  logic [1:0]    occ;
  logic          space, rd_want, wr_want, rd_grant, wr_grant, pop;
  ram_cmd_e      cmd;

  // arb_q == 0 means the next contention goes to the read side.
  always_comb begin
    space    = (ram_cnt_q != FULL_CNT);
    rd_want  = (ram_cnt_q != '0) &&
               (({1'b0, occ} + {2'b00, rd_pend_q}) < 3'(OBUF_DEPTH));
    wr_want  = in_valid & space;
    rd_grant = ~RST & rd_want & (~wr_want | ~arb_q);
    wr_grant = ~RST & wr_want & ~rd_grant;
    pop      = out_valid & out_ready;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(wr_grant);
    rd_ptr_d  = rd_ptr_q + AW'(rd_grant);
    ram_cnt_d = ram_cnt_q + (AW+1)'(wr_grant) - (AW+1)'(rd_grant);
    rd_pend_d = rd_grant;
    arb_d     = (rd_want & wr_want) ? rd_grant : arb_q;
    count_d   = count_q + (AW+2)'(wr_grant) - (AW+2)'(pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      arb_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      arb_q     <= arb_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    cmd = RAM_IDLE;
    if (rd_grant)      cmd = RAM_READ;
    else if (wr_grant) cmd = RAM_WRITE;
  end

  assign {ram_CEN, ram_WEN} = cmd;
  assign ram_A    = rd_grant ? rd_ptr_q : wr_ptr_q;
  assign ram_D    = in_data;
  assign in_ready = ~RST & space & ~rd_grant;
  assign count    = count_q;

  spram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk        (CLK),
    .rst        (RST),
    .push_i     (rd_pend_q),
    .push_data_i(ram_Q),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .occ_o      (occ)
  );

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl (DEPTH=4) with a behavioural single-port RAM that
// returns random junk on ram_Q except in the cycle after a read.
module tb_spram_fifo_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ram_CEN, ram_WEN;
  logic [AW-1:0] ram_A;
  logic [DW-1:0] ram_D, ram_Q;
  logic [AW+1:0] count;

  spram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_CEN(ram_CEN), .ram_WEN(ram_WEN), .ram_A(ram_A), .ram_D(ram_D),
    .ram_Q(ram_Q), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_q_r, junk;
  logic          ram_q_vld = 1'b0;

  always @(posedge CLK) begin
    junk      <= $urandom;
    ram_q_vld <= 1'b0;
    if (!ram_CEN) begin
      if (!ram_WEN) ram_mem[ram_A] <= ram_D;
      else begin
        ram_q_r   <= ram_mem[ram_A];
        ram_q_vld <= 1'b1;
      end
    end
  end
  assign ram_Q = ram_q_vld ? ram_q_r : junk;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- consumer ready ----------------
  int or_mode = 0;  // 0 stall, 1 always ready, 2 toggle, 3 random
  initial forever begin
    @(posedge CLK); #2;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW+1:0] count_m = '0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d = '0;
  logic          alt_on = 1'b0;
  int            alt_idx = 0;
  int            alt_viol = 0;
  logic [1:0]    alt_prev = 2'b11;
  logic [1:0]    alt_first = 2'b11;
  logic [1:0]    cmd_s;

  always @(negedge CLK) begin
    cmd_s = {ram_CEN, ram_WEN};
    if (RST) begin
      exp_q.delete();
      count_m = '0;
      held_v  = 1'b0;
    end else begin
      check("count", count, count_m);
      if (held_v) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, held_d);
      end
      held_v = out_valid & ~out_ready;
      held_d = out_data;
      if (in_valid & in_ready) exp_q.push_back(in_data);
      if (out_valid & out_ready) begin
        check("pop_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("pop_data", out_data, exp_q.pop_front());
      end
      count_m = count_m + (AW+2)'(in_valid & in_ready) - (AW+2)'(out_valid & out_ready);
      if (alt_on && in_valid) begin
        if (alt_idx == 1) alt_first = cmd_s;
        if (alt_idx >= 5 && (cmd_s == alt_prev || cmd_s == 2'b11)) alt_viol++;
        alt_prev = cmd_s;
        alt_idx++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DW-1:0] d);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 200) begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("push_accept", acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    or_mode = 1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge CLK); #1;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    logic seen;

    // reset state, with a producer already offering data
    #1 RST = 1'b1;
    in_valid = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ram_cmd", {ram_CEN, ram_WEN}, 2'b11);
    check("rst_count", count, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    in_valid = 1'b0;
    or_mode = 1;
    @(posedge CLK); #1;

    // single word, minimum latency
    in_valid = 1'b1;
    in_data  = 32'hA5A5_A5A5;
    @(negedge CLK);
    check("sw_in_ready", in_ready, 1'b1);
    check("sw_write_cmd", {ram_CEN, ram_WEN}, 2'b00);
    check("sw_write_addr", ram_A, 0);
    check("sw_write_data", ram_D, 32'hA5A5_A5A5);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    check("sw_read_cmd", {ram_CEN, ram_WEN}, 2'b01);
    check("sw_read_addr", ram_A, 0);
    check("sw_early_valid", out_valid, 1'b0);
    @(negedge CLK);
    check("sw_pend_valid", out_valid, 1'b0);
    check("sw_idle_cmd", {ram_CEN, ram_WEN}, 2'b11);
    @(negedge CLK);
    check("sw_out_valid", out_valid, 1'b1);
    check("sw_out_data", out_data, 32'hA5A5_A5A5);
    drain();

    // full: 4 in RAM + 2 buffered, the 7th is held off
    or_mode = 0;
    @(posedge CLK); #1;
    for (int i = 0; i < 6; i++) push_word(32'h100 + i);
    in_valid = 1'b1;
    in_data  = 32'h106;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("full_in_ready", in_ready, 1'b0);
    end
    check("full_count", count, 6);
    check("full_out_valid", out_valid, 1'b1);
    check("full_head", out_data, 32'h100);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    or_mode = 1;
    push_word(32'h106);
    drain();

    // contention: grants alternate, first contention after reset is a read
    pulse_reset();
    alt_on = 1'b1;
    for (int i = 1; i <= 100; i++) push_word(DW'(i));
    alt_on = 1'b0;
    drain();
    check("first_grant_read", alt_first, 2'b01);
    check("alt_violations", alt_viol, 0);

    // backpressure: out_ready toggles while 16 words stream in
    or_mode = 2;
    for (int i = 0; i < 16; i++) push_word(32'hB000 + i);
    drain();

    // wrap: 13 words with random gaps and random stalls
    or_mode = 3;
    for (int i = 0; i < 13; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
      end
      push_word($urandom);
    end
    drain();
    check("wrap_count", count, 0);

    // mid-operation reset the cycle after a read issues
    or_mode = 0;
    @(posedge CLK); #1;
    push_word(32'h0BAD_0001);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge CLK);
      seen = ~ram_CEN & ram_WEN;
      n++;
    end
    check("mid_read_seen", seen, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b1;
    in_valid = 1'b1;
    @(negedge CLK);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_cmd", {ram_CEN, ram_WEN}, 2'b11);
    check("mid_rst_count", count, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    in_valid = 1'b0;
    or_mode = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("mid_post_valid", out_valid, 1'b0);
      check("mid_post_count", count, 0);
    end
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) push_word(32'hC000 + i);
    drain();
    check("final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
